aes_128: RTL and testbench
==========================

Name: aes_128

Overview:
- Iterative AES-128 engine (FIPS-197) that encrypts or decrypts one 128-bit block per start request.
- Executes one round per clock. Round keys are expanded on-chip from the supplied 128-bit key and stored.
- Sits as a standalone crypto co-processor: the host presents a block, key and mode, pulses start, then waits for done.

Parameters:
- None. Block and key size are fixed at 128 bits; Nr = 10.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- encrypt  input  1  1 = encrypt, 0 = decrypt; latched at start
- plaintext  input  128  input block (plaintext when encrypting, ciphertext when decrypting); latched at start
- key  input  128  cipher key; latched at start
- ciphertext  output  128  result block (ciphertext when encrypting, recovered plaintext when decrypting)
- done  output  1  result valid

Behaviour:
- Byte order follows FIPS-197: bit [127:120] is byte 0. State column c = bytes 4c..4c+3.
- Reset (rst=1 at a clock edge): state goes to IDLE; done=0; ciphertext=0; internal state, key registers and round counter are cleared. Reset wins over any other condition, including mid-operation. An aborted operation produces no output.
- FSM states: IDLE, KEYEXP, INIT, ROUND, DONE.
- IDLE, start=1 at edge k:
  - Latch plaintext, key and encrypt.
  - Store key as rk0.
  - Clear done.
  - Go to KEYEXP.
- KEYEXP, edges k+1..k+10: compute one round key per cycle, rk1..rk10, using RotWord/SubWord/Rcon (01,02,04,08,10,20,40,80,1B,36). Store all 11 round keys. After rk10, go to INIT.
- INIT, edge k+11: state = block XOR rk0 when encrypting, or XOR rk10 when decrypting. Go to ROUND with round = 1.
- ROUND, edges k+12..k+21: one round per cycle.
  - Encrypt round r: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk r). MixColumns is omitted in round 10.
  - Decrypt round r: InvShiftRows, InvSubBytes, AddRoundKey(rk 10−r), InvMixColumns. InvMixColumns is omitted in round 10.
  - After round 10, go to DONE.
- At edge k+21, the final state is written to ciphertext and done is set. Latency is 21 cycles from the start-sampling edge to done visible.
- DONE: done stays 1 and ciphertext holds until the next accepted start, at which point done clears the following cycle. Then continue as from IDLE.
- start while in KEYEXP, INIT or ROUND is ignored. Input changes after latching do not affect the operation in progress.
- S-box and inverse S-box: table or GF(2^8)-inverse-plus-affine implementation. Results must be bit-exact to FIPS-197.
- xtime arithmetic: modulo x^8+x^4+x^3+x+1 (0x11B). All byte operations are 8-bit wrap-free GF(2^8).

Test Plan:
- Encrypt, FIPS-197 C.1: encrypt=1, plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, one-cycle start -> done high 21 cycles later, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt, C.1: encrypt=0, plaintext=69c4e0d86a7b0430d8cdb78070b4c55a, same key -> ciphertext=00112233445566778899aabbccddeeff.
- Encrypt, Appendix B: plaintext=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> ciphertext=3925841d02dc09fbdc118597196a0b32. Then decrypt that ciphertext with the same key -> original block.
- Input disturbance mid-operation: change plaintext, key and encrypt, and pulse start again during ROUND -> result still equals the C.1 vector. done asserts exactly once, at cycle 21.
- Reset mid-operation: assert rst at cycle 8 after start -> done=0 and ciphertext=0. A new start then completes normally with the correct value.
- Back-to-back operations: encrypt then decrypt with start issued in DONE -> done drops for the intervening cycles, and both results are correct.

Source files
------------

// File: rtl/aes_128.sv
// Iterative AES-128 encrypt/decrypt: ten key-expansion cycles, one whitening cycle, then one round per clock.
// done is raised 21 cycles after the start-sampling edge; start is ignored while busy.
module aes_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         encrypt,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         done
);

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_DONE} state_t;

  state_t       r_state, w_next;
  logic [3:0]   r_cnt;
  logic         r_enc;
  logic [127:0] r_blk;
  logic [127:0] r_st;
  logic [127:0] r_klast;
  logic [127:0] r_ct;
  logic         r_done;
  logic [127:0] r_rk [0:10];

  logic [127:0] w_knext;
  logic [127:0] w_round;
  logic [127:0] w_rk;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte 4c+r sits at row r, column c; row r rotates left by r (right by r when inverting)
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a [0:3];
    logic [7:0]   m0, m1, m2, m3;
    m0 = inv ? 8'h0e : 8'h02;
    m1 = inv ? 8'h0b : 8'h03;
    m2 = inv ? 8'h0d : 8'h01;
    m3 = inv ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = gmul(m0, a[r]) ^ gmul(m1, a[(r+1)%4]) ^
                                    gmul(m2, a[(r+2)%4]) ^ gmul(m3, a[(r+3)%4]);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    logic [31:0] w_t, w0, w1, w2, w3;
    w_t = {r_klast[23:0], r_klast[31:24]};
    w_t = {sbox(w_t[31:24]), sbox(w_t[23:16]), sbox(w_t[15:8]), sbox(w_t[7:0])};
    w_t = w_t ^ {rcon(r_cnt), 24'h0};
    w0  = r_klast[127:96] ^ w_t;
    w1  = r_klast[95:64] ^ w0;
    w2  = r_klast[63:32] ^ w1;
    w3  = r_klast[31:0] ^ w2;
    w_knext = {w0, w1, w2, w3};
  end

  assign w_rk = r_enc ? r_rk[r_cnt] : r_rk[4'd10 - r_cnt];

  always_comb begin
    logic [127:0] w_t;
    if (r_enc) begin
      w_t = shift_rows(sub_bytes(r_st, 1'b0), 1'b0);
      if (r_cnt != 4'd10) w_t = mix_columns(w_t, 1'b0);
      w_round = w_t ^ w_rk;
    end else begin
      w_t = sub_bytes(shift_rows(r_st, 1'b1), 1'b1) ^ w_rk;
      if (r_cnt != 4'd10) w_t = mix_columns(w_t, 1'b1);
      w_round = w_t;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_KEYEXP;
      S_KEYEXP:       if (r_cnt == 4'd10) w_next = S_INIT;
      S_INIT:         w_next = S_ROUND;
      S_ROUND:        if (r_cnt == 4'd10) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_enc   <= 1'b0;
      r_blk   <= '0;
      r_st    <= '0;
      r_klast <= '0;
      r_ct    <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i <= 10; i++) r_rk[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_blk   <= plaintext;
            r_enc   <= encrypt;
            r_rk[0] <= key;
            r_klast <= key;
            r_done  <= 1'b0;
            r_cnt   <= 4'd1;
          end
        end
        S_KEYEXP: begin
          r_rk[r_cnt] <= w_knext;
          r_klast     <= w_knext;
          r_cnt       <= r_cnt + 4'd1;
        end
        S_INIT: begin
          r_st  <= r_blk ^ (r_enc ? r_rk[0] : r_rk[10]);
          r_cnt <= 4'd1;
        end
        S_ROUND: begin
          r_st  <= w_round;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd10) begin
            r_ct   <= w_round;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ciphertext = r_ct;
  assign done       = r_done;

endmodule

// File: tb/tb_aes_128.sv
// Directed FIPS-197 vectors for aes_128; a scoreboard queue holds expected results and done timing.
module tb_aes_128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         encrypt = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext;
  logic         done;

  typedef struct {
    logic [127:0] ct;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_done = 1'b0;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_128 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .encrypt    (encrypt),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rising edge of done must match the oldest expected result and its cycle
  always @(negedge clk) begin
    if (!rst && done && !prev_done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 ct=%h, required no result", cyc, ciphertext);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ciphertext !== e.ct) begin
          n_err++;
          $display("FAIL result: got %h, required %h", ciphertext, e.ct);
        end
        n_vec++;
        if (cyc != e.cyc) begin
          n_err++;
          $display("FAIL latency: done at cycle %0d, required %0d", cyc, e.cyc);
        end
      end
    end
    prev_done = done;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge, done is due 21 edges later
  task automatic issue(input logic enc, input logic [127:0] pt, input logic [127:0] k,
                       input logic [127:0] exp_ct, input logic expect_result);
    exp_t e;
    encrypt   = enc;
    plaintext = pt;
    key       = k;
    start     = 1'b1;
    if (expect_result) begin
      e.ct  = exp_ct;
      e.cyc = cyc + 1 + 21;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_done", {127'h0, done}, 128'h0);
    check("reset_ct", ciphertext, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, C1_PT, C1_KEY, C1_CT, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_done", {127'h0, done}, 128'h1);
    check("hold_ct", ciphertext, C1_CT);

    // Back-to-back: start accepted in DONE drops done on the next cycle
    issue(1'b0, C1_CT, C1_KEY, C1_PT, 1'b1);
    check("done_drop", {127'h0, done}, 128'h0);
    wait_idle();

    issue(1'b1, B_PT, B_KEY, B_CT, 1'b1);
    wait_idle();
    issue(1'b0, B_CT, B_KEY, B_PT, 1'b1);
    wait_idle();

    // Disturb inputs and re-pulse start while rounds are running
    issue(1'b1, C1_PT, C1_KEY, C1_CT, 1'b1);
    repeat (12) @(negedge clk);
    encrypt   = 1'b0;
    plaintext = B_CT;
    key       = B_KEY;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    plaintext = 128'hdeadbeef_00000000_ffffffff_12345678;
    wait_idle();
    repeat (25) @(negedge clk);
    check("done_once", {127'h0, done}, 128'h1);

    // Reset at the 8th edge after the start edge aborts the operation
    issue(1'b1, B_PT, B_KEY, 128'h0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", {127'h0, done}, 128'h0);
    check("abort_ct", ciphertext, 128'h0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_quiet", {127'h0, done}, 128'h0);

    issue(1'b1, B_PT, B_KEY, B_CT, 1'b1);
    wait_idle();
    issue(1'b0, C1_CT, C1_KEY, C1_PT, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
